egress_port: RTL and testbench
==============================

EGRESS_PORT -- requirements
Module: egress_port

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 16, giving the packet width in bits. The header is bits [7:0].
REQ-002 SHALL have parameter DEPTH, default 4, giving the egress FIFO entry count. It SHALL be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock, with all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the crossbar output for this port is active this cycle.
REQ-006 SHALL have port in_src, input, 2 bits: the ingress port index selected by the crossbar mux.
REQ-007 SHALL have port in_data, input, PACKET_WIDTH bits: the packet from the crossbar.
REQ-008 SHALL have port in_ready, output, 1 bit: the egress FIFO can accept a packet this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit, registered: the output holds a packet.
REQ-010 SHALL have port out_data, output, PACKET_WIDTH bits, registered: the packet presented downstream.
REQ-011 SHALL have port out_src, output, 2 bits, registered: the ingress index of out_data.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the packet this cycle.
REQ-013 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: FIFO occupancy, excluding the output register.
REQ-014 SHALL have port pkt_cnt, output, 16 bits: delivered-packet count (see Configuration).
REQ-015 SHALL have port drop_cnt, output, 16 bits: dropped-packet count (see Configuration).

Function
REQ-016 SHALL drive in_ready = (fifo_count < DEPTH) combinationally, with no dependence on out_ready.
REQ-017 SHALL push {in_src, in_data} at a rising edge when in_valid && in_ready.
REQ-018 SHALL discard a packet at a rising edge when in_valid && !in_ready, with no FIFO or pointer change.
REQ-019 SHALL be full when fifo_count == DEPTH, even if the output drains in the same cycle; that packet is dropped.
REQ-020 SHALL wrap the read and write pointers modulo DEPTH. Occupancy SHALL never exceed DEPTH or go below 0.
REQ-021 SHALL implement an FSM with states IDLE and SEND. IDLE gives out_valid=0; SEND gives out_valid=1.
REQ-022 In IDLE with the FIFO non-empty, SHALL load the head into out_data/out_src, pop it, and go to SEND.
REQ-023 In SEND with out_ready=1 and the FIFO non-empty, SHALL load and pop the next head and stay in SEND, giving one packet per cycle.
REQ-024 In SEND with out_ready=1 and the FIFO empty, SHALL go to IDLE.
REQ-025 In SEND with out_ready=0, SHALL hold out_data, out_src and out_valid stable.
REQ-026 SHALL give latency: a push at edge N into an empty FIFO and idle output gives out_valid=1 after edge N+1.
REQ-027 SHALL handle simultaneous push and pop in the same cycle so that fifo_count is unchanged and both take effect.
REQ-028 SHALL read a pop from the entry being written in the same cycle only when the FIFO was already non-empty (no write-through bypass).
REQ-029 out_valid SHALL never fall without an out_ready handshake, except on reset.

Reset
REQ-030 On rst_n=0, SHALL immediately clear out_valid, out_data, out_src, the pointers, fifo_count, pkt_cnt and drop_cnt, and enter IDLE, regardless of clk.
REQ-031 A reset during SEND SHALL discard the packet in flight and all queued packets. No handshake SHALL occur until rst_n is back at 1.
REQ-032 in_ready SHALL be 1 while in reset and after it.

Configuration
REQ-033 With EGRESS_STATS_EN defined, pkt_cnt SHALL increment on each out_valid && out_ready edge.
REQ-034 With EGRESS_STATS_EN defined, drop_cnt SHALL increment on each drop edge.
REQ-035 With EGRESS_STATS_EN defined, both counters SHALL saturate at 16'hFFFF.
REQ-036 Without EGRESS_STATS_EN, pkt_cnt and drop_cnt SHALL be tied to 0 and no counter flops SHALL be synthesized.

Verification
REQ-037 Bench SHALL cover a single packet: in_data=16'hA53C, in_src=2 at edge 1 with out_ready=1. Required: out_valid=1 with out_data=16'hA53C and out_src=2 after edge 2, out_valid=0 after edge 3, and pkt_cnt=1.
REQ-038 Bench SHALL cover a full FIFO: out_ready=0 and 6 back-to-back pushes with DEPTH=4. Required: 1 packet in the output register, 4 in the FIFO, in_ready=0 with fifo_count=4, drop_cnt=1, and out_data stable throughout.
REQ-039 Bench SHALL cover streaming: 8 back-to-back pushes with out_ready=1. Required: 8 packets delivered in order, one per cycle, fifo_count <= 1, and no drops.
REQ-040 Bench SHALL cover backpressure: out_ready toggled 1,0,1,0 during a 3-packet stream. Required: out_data holds each packet while out_ready=0, and order is preserved.
REQ-041 Bench SHALL cover reset mid-SEND: rst_n=0 for 1 cycle with 3 packets queued. Required: out_valid=0 at once, fifo_count=0, counters=0, and a later packet has the REQ-026 latency.
REQ-042 Bench SHALL cover pointer wrap: 20 push/pop pairs with DEPTH=4. Required: data integrity across wrap-around, and fifo_count never exceeds 4.

Source files
------------

// File: rtl/egress_port.sv
// egress_port: crossbar egress stage. A DEPTH-entry FIFO of {src, data}
// feeds a registered output stage run by a two-state FSM (IDLE/SEND).
// A packet arriving while the FIFO is full is dropped.
// Optional feature macro: EGRESS_STATS_EN enables saturating delivered and
// dropped packet counters; without it pkt_cnt/drop_cnt are tied to zero.
module egress_port #(
   parameter int PACKET_WIDTH = 16,
   parameter int DEPTH        = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [1:0]                in_src,
   input  logic [PACKET_WIDTH-1:0]   in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [PACKET_WIDTH-1:0]   out_data,
   output logic [1:0]                out_src,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [15:0]               pkt_cnt,
   output logic [15:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = PACKET_WIDTH + 2;
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t         state, state_nxt;
   logic [EW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic           push, pop, drop;

   // Full is judged on the registered occupancy only, so a same-cycle drain
   // never opens a slot for the arriving packet.
   assign in_ready  = (fifo_count < FULL);
   assign push      = in_valid && in_ready;
   assign drop      = in_valid && !in_ready;
   assign out_valid = (state == SEND);

   // Next-state and pop decision; pop only sees pre-edge occupancy, so an
   // entry written this cycle cannot be read through.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_count != '0) begin
               pop       = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (fifo_count != '0) pop       = 1'b1;
               else                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_src, in_data};
   end

   // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Output register loads the FIFO head on every pop, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_src  <= '0;
      end else if (pop) begin
         {out_src, out_data} <= mem[rd_ptr];
      end
   end

`ifdef EGRESS_STATS_EN
   // Saturating delivered/dropped packet counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (out_valid && out_ready && pkt_cnt != 16'hFFFF) pkt_cnt  <= pkt_cnt + 16'd1;
         if (drop && drop_cnt != 16'hFFFF)                  drop_cnt <= drop_cnt + 16'd1;
      end
   end
`else
   assign pkt_cnt  = '0;
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_egress_port.sv
// Directed bench for egress_port: single packet, full FIFO with drop,
// streaming, backpressure, reset mid-SEND and pointer wrap.
module tb_egress_port;

   localparam int PW = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [1:0]    in_src;
   logic [PW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] out_data;
   logic [1:0]    out_src;
   logic          out_ready;
   logic [CW-1:0] fifo_count;
   logic [15:0]   pkt_cnt;
   logic [15:0]   drop_cnt;

   int n_chk   = 0;
   int n_fail  = 0;
   int exp_pkt = 0;
   int exp_drop = 0;
   int delivered = 0;
   int d0;
   logic [17:0] q[$];

   egress_port #(.PACKET_WIDTH(PW), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_src(in_src), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src), .out_ready(out_ready),
      .fifo_count(fifo_count), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] stat(input int v);
`ifdef EGRESS_STATS_EN
      return v[15:0];
`else
      return (v > 0) ? 16'h0 : 16'h0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Score a handshake happening at the coming edge, then advance one cycle.
   task automatic tick_hs();
      logic [17:0] e;
      if (out_valid && out_ready) begin
         chk("hs_queue_nonempty", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("hs_data", 32'({out_src, out_data}), 32'(e));
         end
         exp_pkt++;
         delivered++;
      end
      tick();
   endtask

   task automatic drive(input logic [1:0] s, input logic [15:0] d);
      in_valid = 1'b1;
      in_src   = s;
      in_data  = d;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 40 && (out_valid || q.size() != 0); k++) tick_hs();
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_queue_empty", 32'(q.size()), 32'd0);
      chk("drain_fifo_count", 32'(fifo_count), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_src = '0; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_data", 32'({out_src, out_data}), 32'd0);
      chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      // Single packet.
      drive(2'd2, 16'hA53C);
      out_ready = 1'b1;
      q.push_back({2'd2, 16'hA53C});
      tick_hs();
      in_valid = 1'b0;
      chk("single_e1_out_valid", 32'(out_valid), 32'd0);
      chk("single_e1_fifo_count", 32'(fifo_count), 32'd1);
      tick_hs();
      chk("single_e2_out_valid", 32'(out_valid), 32'd1);
      chk("single_e2_out_data", 32'(out_data), 32'hA53C);
      chk("single_e2_out_src", 32'(out_src), 32'd2);
      tick_hs();
      chk("single_e3_out_valid", 32'(out_valid), 32'd0);
      chk("single_pkt_cnt", 32'(pkt_cnt), 32'(stat(exp_pkt)));

      // Full FIFO: six pushes with no drain; the sixth is dropped.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(2'(i), 16'h1000 + 16'(i));
         if (i < 5) q.push_back({2'(i), 16'h1000 + 16'(i)});
         else begin
            chk("full_in_ready_before_drop", 32'(in_ready), 32'd0);
            exp_drop++;
         end
         tick_hs();
         if (i >= 1) chk("full_out_data_stable", 32'(out_data), 32'h1000);
      end
      in_valid = 1'b0;
      chk("full_out_valid", 32'(out_valid), 32'd1);
      chk("full_fifo_count", 32'(fifo_count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_drop_cnt", 32'(drop_cnt), 32'(stat(exp_drop)));
      drain();
      chk("full_pkt_cnt", 32'(pkt_cnt), 32'(stat(exp_pkt)));

      // Streaming: one packet per cycle, occupancy stays at most 1.
      d0 = delivered;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(2'(i), 16'h2000 + 16'(i));
         q.push_back({2'(i), 16'h2000 + 16'(i)});
         chk("stream_in_ready", 32'(in_ready), 32'd1);
         tick_hs();
         chk("stream_fifo_le1", 32'(fifo_count <= 1), 32'd1);
         if (i >= 1) chk("stream_out_valid", 32'(out_valid), 32'd1);
      end
      drain();
      chk("stream_delivered", 32'(delivered - d0), 32'd8);
      chk("stream_drop_cnt", 32'(drop_cnt), 32'(stat(exp_drop)));

      // Backpressure: out_ready 1,0,1,0 across a 3-packet stream.
      drive(2'd1, 16'h3000); out_ready = 1'b0; tick();
      drive(2'd2, 16'h3001); tick();
      chk("bp_e2_data", 32'({out_valid, out_src, out_data}), 32'h1_3000 | 32'h4_0000);
      drive(2'd3, 16'h3002); out_ready = 1'b1; tick();
      in_valid = 1'b0;
      chk("bp_e3_data", 32'({out_valid, out_src, out_data}), 32'h6_3001);
      out_ready = 1'b0; tick();
      chk("bp_e4_hold", 32'({out_valid, out_src, out_data}), 32'h6_3001);
      out_ready = 1'b1; tick();
      chk("bp_e5_data", 32'({out_valid, out_src, out_data}), 32'h7_3002);
      out_ready = 1'b0; tick();
      chk("bp_e6_hold", 32'({out_valid, out_src, out_data}), 32'h7_3002);
      out_ready = 1'b1; tick();
      chk("bp_e7_idle", 32'(out_valid), 32'd0);
      exp_pkt += 3;
      chk("bp_pkt_cnt", 32'(pkt_cnt), 32'(stat(exp_pkt)));

      // Reset mid-SEND with three packets queued.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(2'(i), 16'h4000 + 16'(i));
         tick();
      end
      in_valid = 1'b0;
      chk("rstmid_pre_fifo_count", 32'(fifo_count), 32'd3);
      chk("rstmid_pre_out_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_out_valid", 32'(out_valid), 32'd0);
      chk("rstmid_fifo_count", 32'(fifo_count), 32'd0);
      chk("rstmid_pkt_cnt", 32'(pkt_cnt), 32'd0);
      chk("rstmid_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rstmid_in_ready", 32'(in_ready), 32'd1);
      exp_pkt = 0; exp_drop = 0; q.delete();
      tick();
      chk("rstmid_hold_out_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      drive(2'd3, 16'h5A5A);
      q.push_back({2'd3, 16'h5A5A});
      tick_hs();
      in_valid = 1'b0;
      chk("post_rst_latency_n", 32'(out_valid), 32'd0);
      tick_hs();
      chk("post_rst_latency_n1", 32'({out_valid, out_src, out_data}), 32'h7_5A5A);
      drain();
      chk("post_rst_pkt_cnt", 32'(pkt_cnt), 32'(stat(exp_pkt)));

      // Pointer wrap: 20 packets with ~2 entries resident so pointers lap 5 times.
      d0 = delivered;
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) out_ready = 1'b1;
         drive(2'(i), 16'h6000 + 16'(i * 7));
         q.push_back({2'(i), 16'h6000 + 16'(i * 7)});
         tick_hs();
         chk("wrap_fifo_le_depth", 32'(fifo_count <= 4), 32'd1);
      end
      drain();
      chk("wrap_delivered", 32'(delivered - d0), 32'd20);
      chk("wrap_pkt_cnt", 32'(pkt_cnt), 32'(stat(exp_pkt)));
      chk("wrap_drop_cnt", 32'(drop_cnt), 32'(stat(exp_drop)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
